store_arbiter: RTL

- Shares one memory write port between N_STORES dataflow store ports.
- Each port presents separate data and address channels. The block joins the two channels, picks one port by round-robin, and registers the winning address/data pair into a one-slot output stage toward the memory interface.
- Sits between the store units and a single-write-port memory controller.

---
 rtl/store_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/store_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_arbiter: joins per-port data/address channels, round-robin grant,  |
// | one-slot registered write stage. STORE_ARB_FIXED_PRIO_EN = fixed prio.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module store_arbiter #(
  parameter int N_STORES  = 2,
  parameter int DATA_TYPE = 32,
  parameter int ADDR_TYPE = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_STORES*DATA_TYPE-1:0]   dataIn,
  input  logic [N_STORES-1:0]             dataIn_valid,
  output logic [N_STORES-1:0]             dataIn_ready,
  input  logic [N_STORES*ADDR_TYPE-1:0]   addrIn,
  input  logic [N_STORES-1:0]             addrIn_valid,
  output logic [N_STORES-1:0]             addrIn_ready,
  output logic [DATA_TYPE-1:0]            dataToMem,
  output logic [ADDR_TYPE-1:0]            addrOut,
  output logic                            memValid,
  input  logic                            memReady,
  output logic [((N_STORES > 1) ? $clog2(N_STORES) : 1)-1:0] memPortId
);

  localparam int c_IdW = (N_STORES > 1) ? $clog2(N_STORES) : 1;

  logic [N_STORES-1:0]  w_eligible;
  logic                 w_load;
  logic                 w_xfer;
  logic                 w_hiFound;
  logic                 w_loFound;
  logic [c_IdW-1:0]     w_hiGrant;
  logic [c_IdW-1:0]     w_loGrant;
  logic [c_IdW-1:0]     w_grant;
  logic [c_IdW-1:0]     w_start;
  logic [DATA_TYPE-1:0] w_data;
  logic [ADDR_TYPE-1:0] w_addr;

  logic                 r_memValid;
  logic [DATA_TYPE-1:0] r_data;
  logic [ADDR_TYPE-1:0] r_addr;
  logic [c_IdW-1:0]     r_portId;

  assign w_eligible = dataIn_valid & addrIn_valid;
  assign w_load     = ~r_memValid | memReady;

`ifdef STORE_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [c_IdW-1:0] r_ptr;
  assign w_start = r_ptr;
`endif

  // Rotating search: the first eligible port at or above the start index
  // wins; otherwise wrap to the lowest eligible port below it.
  always_comb begin
    w_hiFound = 1'b0;
    w_loFound = 1'b0;
    w_hiGrant = '0;
    w_loGrant = '0;
    for (int i = 0; i < N_STORES; i++) begin
      if (!w_hiFound && w_eligible[i] && (c_IdW'(i) >= w_start)) begin
        w_hiFound = 1'b1;
        w_hiGrant = c_IdW'(i);
      end
      if (!w_loFound && w_eligible[i]) begin
        w_loFound = 1'b1;
        w_loGrant = c_IdW'(i);
      end
    end
    w_grant = w_hiFound ? w_hiGrant : w_loGrant;
  end

  always_comb begin
    w_data = '0;
    w_addr = '0;
    for (int i = 0; i < N_STORES; i++) begin
      if (w_grant == c_IdW'(i)) begin
        w_data = dataIn[i*DATA_TYPE +: DATA_TYPE];
        w_addr = addrIn[i*ADDR_TYPE +: ADDR_TYPE];
      end
    end
  end

  assign w_xfer = w_loFound & w_load;

  generate
    for (genvar i = 0; i < N_STORES; i++) begin : g_ready
      assign dataIn_ready[i] = w_xfer & ~rst & (w_grant == c_IdW'(i));
      assign addrIn_ready[i] = w_xfer & ~rst & (w_grant == c_IdW'(i));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_memValid <= 1'b0;
      r_data     <= '0;
      r_addr     <= '0;
      r_portId   <= '0;
    end else if (w_load) begin
      if (w_loFound) begin
        r_memValid <= 1'b1;
        r_data     <= w_data;
        r_addr     <= w_addr;
        r_portId   <= w_grant;
      end else begin
        r_memValid <= 1'b0;
      end
    end
  end

`ifndef STORE_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_grant == c_IdW'(N_STORES - 1)) ? '0 : w_grant + 1'b1;
    end
  end
`endif

  assign memValid  = r_memValid;
  assign dataToMem = r_data;
  assign addrOut   = r_addr;
  assign memPortId = r_portId;

endmodule
`default_nettype wire
